// File: rtl/seg_reader_pkg.sv
// Shared 7-segment definitions used by the segment decoder and the reader.
package seg_reader_pkg;

  // Segment codes, a..g in bits 6..0, active low.
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Digit values reported for a blank position and for an illegal pattern.
  localparam logic [3:0] DIG_BLANK = 4'hF;
  localparam logic [3:0] DIG_BAD   = 4'hE;

  // What an accepted bus pattern asks the reader to do.
  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_MUX,
    ACT_WRITE
  } act_e;

endpackage

// File: rtl/seg_reader_lookup.sv
// Reverse segment table: 7-bit active-low pattern to BCD digit plus legal flag.
module seg_lookup
  import seg_reader_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       legal
);

  // Blank is legal and reads as DIG_BLANK; anything unlisted reads as DIG_BAD.
  always_comb begin
    digit = DIG_BAD;
    legal = 1'b0;
    case (pattern)
      SEG_0:     begin digit = 4'd0;      legal = 1'b1; end
      SEG_1:     begin digit = 4'd1;      legal = 1'b1; end
      SEG_2:     begin digit = 4'd2;      legal = 1'b1; end
      SEG_3:     begin digit = 4'd3;      legal = 1'b1; end
      SEG_4:     begin digit = 4'd4;      legal = 1'b1; end
      SEG_5:     begin digit = 4'd5;      legal = 1'b1; end
      SEG_6:     begin digit = 4'd6;      legal = 1'b1; end
      SEG_7:     begin digit = 4'd7;      legal = 1'b1; end
      SEG_8:     begin digit = 4'd8;      legal = 1'b1; end
      SEG_9:     begin digit = 4'd9;      legal = 1'b1; end
      SEG_BLANK: begin digit = DIG_BLANK; legal = 1'b1; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/seg_reader.sv
// Multiplexed active-low 7-segment bus reader with stability filtering.
module seg_reader
  import seg_reader_pkg::*;
#(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [N_DIGITS-1:0]   AN,
  input  logic [7:0]            SEG,
  output logic [4*N_DIGITS-1:0] DIGITS,
  output logic [N_DIGITS-1:0]   DP,
  output logic [N_DIGITS-1:0]   ERR,
  output logic                  UPD,
  output logic [2:0]            UPD_IDX,
  output logic                  FRAME,
  output logic                  MUX_ERR
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int SW    = N_DIGITS + 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYCLES - 1);

  logic [SW-1:0]       samp;
  logic [CNT_W-1:0]    cnt;
  logic                accept;
  logic                same;
  logic [N_DIGITS-1:0] seen;
  logic [N_DIGITS-1:0] seen_next;
  logic [N_DIGITS-1:0] an_s;
  logic [7:0]          seg_s;
  logic [N_DIGITS-1:0] sel;
  logic [2:0]          idx;
  int unsigned         lows;
  act_e                act;
  logic [3:0]          lk_digit;
  logic                lk_legal;

  assign an_s  = samp[SW-1:8];
  assign seg_s = samp[7:0];

  seg_lookup u_lookup (
    .pattern (seg_s[7:1]),
    .digit   (lk_digit),
    .legal   (lk_legal)
  );

  // Compare the incoming bus against the last sample.
  always_comb begin
    same = ({AN, SEG} == samp);
  end

  // Sample register, saturating stability counter and one-shot accept strobe.
  // The accept strobe is registered, so on the following edge samp still holds
  // the accepted pattern and the output stage can decode it directly.
  always_ff @(posedge CLK) begin
    if (RST) begin
      samp   <= '1;
      cnt    <= '0;
      accept <= 1'b0;
    end else begin
      samp   <= {AN, SEG};
      accept <= same && (cnt == CNT_PRE);
      if (!same) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Classify the held pattern by how many digit enables are active.
  always_comb begin
    act  = ACT_NONE;
    sel  = '0;
    idx  = '0;
    lows = 0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (!an_s[i]) begin
        lows   = lows + 1;
        sel[i] = 1'b1;
        idx    = 3'(i);
      end
    end
    if (lows == 1) begin
      act = ACT_WRITE;
    end else if (lows > 1) begin
      act = ACT_MUX;
    end
    seen_next = seen | sel;
  end

  // Digit registers, strobes and frame tracking, written one edge after accept.
  always_ff @(posedge CLK) begin
    if (RST) begin
      DIGITS  <= '1;
      DP      <= '0;
      ERR     <= '0;
      UPD     <= 1'b0;
      UPD_IDX <= '0;
      FRAME   <= 1'b0;
      MUX_ERR <= 1'b0;
      seen    <= '0;
    end else begin
      UPD     <= 1'b0;
      FRAME   <= 1'b0;
      MUX_ERR <= 1'b0;
      if (accept) begin
        case (act)
          ACT_MUX: MUX_ERR <= 1'b1;
          ACT_WRITE: begin
            for (int unsigned i = 0; i < N_DIGITS; i++) begin
              if (sel[i]) begin
                DIGITS[4*i +: 4] <= lk_digit;
                DP[i]            <= ~seg_s[0];
                ERR[i]           <= ~lk_legal;
              end
            end
            UPD     <= 1'b1;
            UPD_IDX <= idx;
            if (&seen_next) begin
              FRAME <= 1'b1;
              seen  <= '0;
            end else begin
              seen  <= seen_next;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_reader.sv
// Scoreboard bench for seg_reader: run-length reference model feeds a queue,
// a negedge monitor pops and compares whenever the DUT pulses an output.
module tb_seg_reader;

  localparam int N = 4;
  localparam int S = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic [N-1:0]  AN;
  logic [7:0]    SEG;
  logic [4*N-1:0] DIGITS;
  logic [N-1:0]  DP;
  logic [N-1:0]  ERR;
  logic          UPD;
  logic [2:0]    UPD_IDX;
  logic          FRAME;
  logic          MUX_ERR;

  seg_reader #(.N_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .CLK(CLK), .RST(RST), .AN(AN), .SEG(SEG),
    .DIGITS(DIGITS), .DP(DP), .ERR(ERR),
    .UPD(UPD), .UPD_IDX(UPD_IDX), .FRAME(FRAME), .MUX_ERR(MUX_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          upd;
    bit          mux;
    bit          frame;
    logic [2:0]  idx;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  err;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: what the display should show, and which digits were seen.
  logic [3:0] m_dig[N];
  logic [3:0] m_dp;
  logic [3:0] m_err;
  logic [3:0] m_seen;

  // Current run of identical samples on the bus.
  logic [11:0] cur_val;
  int          cur_len;
  bit          fired;

  logic [6:0] codes[10];
  initial begin
    codes = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
              7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [15:0] pack_digits();
    logic [15:0] r;
    for (int k = 0; k < N; k++) r[4*k +: 4] = m_dig[k];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_dig[k] = 4'hF;
    m_dp    = '0;
    m_err   = '0;
    m_seen  = '0;
    cur_val = 12'hFFF;
    cur_len = 1;
    fired   = 1'b0;
  endtask

  // Effect of a pattern that has been stable long enough.
  task automatic model_accept(input logic [3:0] an, input logic [7:0] seg);
    int   lows;
    int   pos;
    exp_t e;
    logic [3:0] d;
    bit   bad;
    lows = 0;
    pos  = 0;
    for (int k = 0; k < N; k++) if (an[k] == 1'b0) begin lows++; pos = k; end
    if (lows == 0) return;
    e = '{upd: 1'b0, mux: 1'b0, frame: 1'b0, idx: 3'd0, digits: 16'h0, dp: 4'h0, err: 4'h0};
    if (lows > 1) begin
      e.mux = 1'b1;
      q.push_back(e);
      return;
    end
    d   = 4'hE;
    bad = 1'b1;
    if (seg[7:1] == 7'b1111111) begin d = 4'hF; bad = 1'b0; end
    for (int k = 0; k < 10; k++) if (seg[7:1] == codes[k]) begin d = 4'(k); bad = 1'b0; end
    m_dig[pos]  = d;
    m_dp[pos]   = ~seg[0];
    m_err[pos]  = bad;
    m_seen[pos] = 1'b1;
    e.upd    = 1'b1;
    e.idx    = 3'(pos);
    e.digits = pack_digits();
    e.dp     = m_dp;
    e.err    = m_err;
    if (m_seen == 4'hF) begin
      e.frame = 1'b1;
      m_seen  = '0;
    end
    q.push_back(e);
  endtask

  // Drive a bus value for n sampling edges and update the run-length model.
  task automatic hold(input logic [3:0] an, input logic [7:0] seg, input int n);
    logic [11:0] v;
    v = {an, seg};
    if (v != cur_val) begin
      cur_val = v;
      cur_len = 0;
      fired   = 1'b0;
    end
    cur_len += n;
    if (!fired && cur_len >= S + 1) begin
      fired = 1'b1;
      model_accept(an, seg);
    end
    AN  = an;
    SEG = seg;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    AN  = '1;
    SEG = '1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
  endtask

  task automatic chk_reset_state();
    chk("rst_digits", 32'(DIGITS), 32'hFFFF);
    chk("rst_dp", 32'(DP), 0);
    chk("rst_err", 32'(ERR), 0);
    chk("rst_upd", 32'(UPD), 0);
    chk("rst_idx", 32'(UPD_IDX), 0);
    chk("rst_frame", 32'(FRAME), 0);
    chk("rst_mux", 32'(MUX_ERR), 0);
  endtask

  // Monitor: every output pulse must match the oldest expected event.
  always @(negedge CLK) begin
    if (!RST && (UPD || MUX_ERR || FRAME)) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pulse: got upd=%0b mux=%0b frame=%0b required none at %0t",
                 UPD, MUX_ERR, FRAME, $time);
      end else begin
        mon_e = q.pop_front();
        chk("mon_upd", 32'(UPD), 32'(mon_e.upd));
        chk("mon_mux", 32'(MUX_ERR), 32'(mon_e.mux));
        chk("mon_frame", 32'(FRAME), 32'(mon_e.frame));
        if (mon_e.upd) begin
          chk("mon_idx", 32'(UPD_IDX), 32'(mon_e.idx));
          chk("mon_digits", 32'(DIGITS), 32'(mon_e.digits));
          chk("mon_dp", 32'(DP), 32'(mon_e.dp));
          chk("mon_err", 32'(ERR), 32'(mon_e.err));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] an;
    logic [7:0] seg;
    logic [6:0] s7;
    int         r;
    int         i0, i1;

    do_reset();
    chk_reset_state();
    hold(4'b1111, 8'hFF, 8);
    chk("idle_digits", 32'(DIGITS), 32'hFFFF);

    // Single digit, exact latency, no repeat while held.
    hold(4'b1110, 8'b00001101, 5);
    chk("lat_pre", 32'(UPD), 0);
    hold(4'b1110, 8'b00001101, 1);
    chk("lat_upd", 32'(UPD), 1);
    chk("lat_idx", 32'(UPD_IDX), 0);
    chk("lat_digit", 32'(DIGITS[3:0]), 3);
    chk("lat_dp", 32'(DP[0]), 0);
    hold(4'b1110, 8'b00001101, 4);
    chk("held_no_upd", 32'(UPD), 0);

    // Too short to accept.
    hold(4'b1111, 8'hFF, 2);
    hold(4'b1110, 8'b00001101, 3);
    hold(4'b1111, 8'hFF, 6);
    chk("short_digit", 32'(DIGITS[3:0]), 3);

    // Full scan 1,2,3,4 with dp on digit 3.
    hold(4'b1110, 8'b10011111, 6);
    hold(4'b1101, 8'b00100101, 6);
    hold(4'b1011, 8'b00001101, 6);
    hold(4'b0111, 8'b10011000, 6);
    hold(4'b1111, 8'hFF, 6);
    chk("scan_digits", 32'(DIGITS), 32'h4321);
    chk("scan_dp", 32'(DP), 32'b1000);

    // Two enables low, then an illegal pattern.
    hold(4'b1100, 8'b00000011, 5);
    hold(4'b1111, 8'hFF, 3);
    hold(4'b1101, 8'b11100001, 6);
    hold(4'b1111, 8'hFF, 6);
    chk("bad_digit", 32'(DIGITS[7:4]), 32'hE);
    chk("bad_err", 32'(ERR[1]), 1);

    // Reset mid-stability discards the partial count.
    hold(4'b1011, 8'b00100101, 3);
    do_reset();
    chk_reset_state();
    hold(4'b1011, 8'b00100101, 4);
    chk("fresh_no_upd", 32'(UPD), 0);
    hold(4'b1011, 8'b00100101, 1);
    hold(4'b1011, 8'b00100101, 1);
    chk("fresh_upd", 32'(UPD), 1);
    chk("fresh_digit", 32'(DIGITS[11:8]), 2);

    // Randomized bus traffic.
    an  = 4'hF;
    seg = 8'hFF;
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 4) != 0) begin
        r = $urandom_range(0, 9);
        if (r == 0) begin
          an = 4'hF;
        end else if (r == 1) begin
          i0 = $urandom_range(0, N - 1);
          i1 = (i0 + $urandom_range(1, N - 1)) % N;
          an = 4'hF;
          an[i0] = 1'b0;
          an[i1] = 1'b0;
        end else begin
          an = 4'hF;
          an[$urandom_range(0, N - 1)] = 1'b0;
        end
        r = $urandom_range(0, 9);
        if (r <= 6)      s7 = codes[$urandom_range(0, 9)];
        else if (r == 7) s7 = 7'b1111111;
        else             s7 = 7'($urandom);
        seg = {s7, 1'($urandom)};
      end
      hold(an, seg, $urandom_range(1, 8));
    end

    hold(4'b1111, 8'hFF, S + 4);
    chk("queue_drained", 32'(q.size()), 0);
    chk("final_digits", 32'(DIGITS), 32'(pack_digits()));
    chk("final_dp", 32'(DP), 32'(m_dp));
    chk("final_err", 32'(ERR), 32'(m_err));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
